// File: rtl/vedic_mac_pkg.sv
// vedic_mac_pkg: state encoding and default widths shared by vedic_mac_acc.
package vedic_mac_pkg;

   localparam int unsigned ACC_W_DEF = 40;
   localparam int unsigned CNT_W_DEF = 8;
   localparam int unsigned PROD_W    = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/vedic_mac_acc_cla_add.sv
// cla_add_acc: W-bit carry-lookahead adder built from 4-bit lookahead groups
// with the group carries chained; operands are zero-padded to a whole group.
module cla_add_acc #(
   parameter int unsigned W = 40
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   localparam int unsigned NG = (W + 3) / 4;
   localparam int unsigned PW = NG * 4;

   logic [PW-1:0] a_x;
   logic [PW-1:0] b_x;
   logic [PW-1:0] g;
   logic [PW-1:0] p;
   logic [PW-1:0] s_x;
   logic [PW:0]   c;

   always_comb begin
      a_x        = '0;
      b_x        = '0;
      a_x[W-1:0] = a;
      b_x[W-1:0] = b;
      g          = a_x & b_x;
      p          = a_x ^ b_x;
      c          = '0;
      c[0]       = cin;
      // Every carry inside a group is expanded from the group's carry-in.
      for (int unsigned k = 0; k < NG; k++) begin
         c[4*k+1] = g[4*k]
                  | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1]
                  | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2]
                  | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
      s_x = p ^ c[PW-1:0];
   end

   assign sum  = s_x[W-1:0];
   assign cout = c[W];

endmodule

// File: rtl/vedic_mac_acc.sv
// vedic_mac_acc: frame accumulator for 32-bit products with IDLE/ACCUM/HOLD FSM.
// Define VEDIC_MAC_SAT_EN to saturate the sum on overflow instead of wrapping.
module vedic_mac_acc
   import vedic_mac_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   input  logic              prod_last,
   output logic              in_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  acc_cnt,
   output logic              acc_ovf,
   output logic              acc_valid,
   input  logic              acc_ready
);

   state_e            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;
   logic              rdy_q, rdy_d;

   logic              accept;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W-1:0]  add_sum;
   logic              add_cout;
   logic [ACC_W-1:0]  acc_next;
   logic [CNT_W-1:0]  cnt_inc;

   assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};
   assign accept   = prod_valid & rdy_q;

   cla_add_acc #(
      .W (ACC_W)
   ) u_add (
      .a    (acc_q),
      .b    (prod_ext),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
`ifdef VEDIC_MAC_SAT_EN
      acc_next = add_cout ? '1 : add_sum;
`else
      acc_next = add_sum;
`endif
      cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      if (clr) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  acc_d   = prod_ext;
                  cnt_d   = CNT_W'(1);
                  ovf_d   = 1'b0;
                  state_d = prod_last ? HOLD : ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  acc_d   = acc_next;
                  cnt_d   = cnt_inc;
                  ovf_d   = ovf_q | add_cout;
                  state_d = prod_last ? HOLD : ACCUM;
               end
            end
            HOLD: begin
               if (acc_ready) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // Handshake outputs are registered, so derive them from the next state.
      valid_d = (state_d == HOLD);
      rdy_d   = (state_d != HOLD);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
         rdy_q   <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign acc_valid = valid_q;
   assign acc_out   = acc_q;
   assign acc_cnt   = cnt_q;
   assign acc_ovf   = ovf_q;

endmodule
